hhv2_ctrl: RTL

// - Sequencer/arbiter for the combinational 31-stage hyperbolic vectoring CORDIC (HHV2, Q8.24).
// - Shares one core between two requesters (round-robin), registers the core operand,

---
 rtl/hhv2_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/hhv2_ctrl.sv
// rtl/hhv2_ctrl.sv - HHV2 CORDIC sequencer/arbiter; optional range check via HHV2_RANGE_CHK_EN
module hhv2_ctrl #(
  parameter int DW     = 32,
  parameter int SETTLE = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [1:0]    req_valid,
  input  logic [DW-1:0] req_data0,
  input  logic [DW-1:0] req_data1,
  output logic [1:0]    req_ready,
  output logic [DW-1:0] core_d,
  input  logic [DW-1:0] core_x,
  input  logic [DW-1:0] core_y,
  input  logic [DW-1:0] core_z,
  output logic          res_valid,
  input  logic          res_ready,
  output logic [DW-1:0] res_x,
  output logic [DW-1:0] res_y,
  output logic [DW-1:0] res_z,
  output logic          res_tag,
  output logic          busy
`ifdef HHV2_RANGE_CHK_EN
  ,
  output logic          err
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [7:0] CNT_INIT = 8'(SETTLE - 1);

  state_t        state;
  logic          rr_ptr;
  logic [7:0]    cnt;
  logic          grant;
  logic          grant_any;
  logic [DW-1:0] sel_data;

  // Round-robin grant, offered only in IDLE and never while reset is held
  always_comb begin
    grant     = rr_ptr;
    grant_any = 1'b0;
    if (state == IDLE && !rst) begin
      if (req_valid[rr_ptr]) begin
        grant_any = 1'b1;
      end else if (req_valid[~rr_ptr]) begin
        grant     = ~rr_ptr;
        grant_any = 1'b1;
      end
    end
  end

  assign req_ready = grant_any ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign sel_data  = grant ? req_data1 : req_data0;
  assign busy      = (state != IDLE);

`ifdef HHV2_RANGE_CHK_EN
  // D <= 0 is outside the hyperbolic vectoring domain
  logic bad;
  assign bad = sel_data[DW-1] | (sel_data == '0);
`endif

  // Sequencer: accept, hold operand for the multicycle path, capture, hand off
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= 8'd0;
      core_d    <= '0;
      res_x     <= '0;
      res_y     <= '0;
      res_z     <= '0;
      res_tag   <= 1'b0;
      res_valid <= 1'b0;
`ifdef HHV2_RANGE_CHK_EN
      err       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (grant_any) begin
            res_tag <= grant;
            rr_ptr  <= ~grant;
`ifdef HHV2_RANGE_CHK_EN
            if (bad) begin
              // Rejected operand: core_d keeps the last good value, zero result flagged
              res_x <= '0;
              res_y <= '0;
              res_z <= '0;
              err   <= 1'b1;
              state <= DONE;
            end else begin
              core_d <= sel_data;
              err    <= 1'b0;
              cnt    <= CNT_INIT;
              state  <= WAIT;
            end
`else
            core_d <= sel_data;
            cnt    <= CNT_INIT;
            state  <= WAIT;
`endif
          end
        end
        WAIT: begin
          if (cnt == 8'd0) begin
            res_x     <= core_x;
            res_y     <= core_y;
            res_z     <= core_z;
            res_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        DONE: begin
          // A rejected operand enters DONE with res_valid low; raise it one edge later
          if (!res_valid) begin
            res_valid <= 1'b1;
          end else if (res_ready) begin
            res_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
